uart_transmitter: RTL and testbench

UART transmit stage that sits directly downstream of the baud controller: it consumes the 16x-oversampled `sample_ENABLE` strobe and serialises one byte per write request onto `TxD`. Frame format is 1 start bit, 8 data bits LSB-first, an optional even-parity bit, and 1 stop bit. It feeds the board TX pin and, in loopback benches, the UART receiver.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_transmitter_baud_controller.sv | 31 +++
 rtl/uart_transmitter.sv | 127 ++++++++++++
 tb/tb_uart_transmitter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, frame geometry and baud_select codes.
// The optional even-parity bit is controlled by the UART_TX_PARITY_EN macro in the users of this package.
package uart_pkg;

   localparam int SAMPLES_PER_BIT = 16;
   localparam int DATA_BITS       = 8;
   localparam int DIV_W           = 15;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic [2:0] BAUD_300    = 3'b000;
   localparam logic [2:0] BAUD_1200   = 3'b001;
   localparam logic [2:0] BAUD_4800   = 3'b010;
   localparam logic [2:0] BAUD_9600   = 3'b011;
   localparam logic [2:0] BAUD_19200  = 3'b100;
   localparam logic [2:0] BAUD_38400  = 3'b101;
   localparam logic [2:0] BAUD_57600  = 3'b110;
   localparam logic [2:0] BAUD_115200 = 3'b111;

   // Clock cycles per sample strobe: 100 MHz / (16 * baud), rounded to nearest.
   function automatic logic [DIV_W-1:0] baud_divisor(input logic [2:0] sel);
      case (sel)
         BAUD_300:    return 15'd20833;
         BAUD_1200:   return 15'd5208;
         BAUD_4800:   return 15'd1302;
         BAUD_9600:   return 15'd651;
         BAUD_19200:  return 15'd326;
         BAUD_38400:  return 15'd163;
         BAUD_57600:  return 15'd109;
         default:     return 15'd54;
      endcase
   endfunction

endpackage

// File: rtl/uart_transmitter_baud_controller.sv
// Free-running baud generator: one-cycle sample_ENABLE pulse at 16x the selected baud rate.
// Shared by the UART transmitter and receiver; not dependent on UART_TX_PARITY_EN.
module Baud_controller
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   output logic       sample_ENABLE
);

   logic [DIV_W-1:0] count;
   logic [DIV_W-1:0] limit;

   assign limit = baud_divisor(baud_select) - 1'b1;

   // Compare with >= so a shorter divisor selected mid-count wraps immediately.
   always_ff @(posedge clk) begin
      if (reset) begin
         count         <= '0;
         sample_ENABLE <= 1'b0;
      end else if (count >= limit) begin
         count         <= '0;
         sample_ENABLE <= 1'b1;
      end else begin
         count         <= count + 1'b1;
         sample_ENABLE <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, LSB-first data, optional even parity (UART_TX_PARITY_EN), stop bit.
// Bit timing comes from the internal Baud_controller sample strobe; TxD and Tx_BUSY are registered.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int SAMPLES_PER_BIT = uart_pkg::SAMPLES_PER_BIT,
   parameter int DATA_BITS       = uart_pkg::DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           baud_select,
   input  logic                 Tx_EN,
   input  logic                 Tx_WR,
   input  logic [DATA_BITS-1:0] Tx_DATA,
   output logic                 TxD,
   output logic                 Tx_BUSY
);

   localparam int SCW = $clog2(SAMPLES_PER_BIT);
   localparam int BCW = $clog2(DATA_BITS);

   tx_state_t            state, state_next;
   logic [DATA_BITS-1:0] shift, shift_next;
   logic [SCW-1:0]       sample_cnt, sample_next;
   logic [BCW-1:0]       bit_cnt, bit_next;
   logic                 txd_next, busy_next, bit_done;
   logic                 sample_ENABLE;
`ifdef UART_TX_PARITY_EN
   logic                 parity, parity_next;
`endif

   Baud_controller baud (
      .clk           (clk),
      .reset         (reset),
      .baud_select   (baud_select),
      .sample_ENABLE (sample_ENABLE)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         sample_cnt <= '0;
         bit_cnt    <= '0;
         TxD        <= 1'b1;
         Tx_BUSY    <= 1'b0;
      end else begin
         state      <= state_next;
         sample_cnt <= sample_next;
         bit_cnt    <= bit_next;
         TxD        <= txd_next;
         Tx_BUSY    <= busy_next;
      end
   end

   // Payload registers need no reset: they are reloaded on every accepted write.
   always_ff @(posedge clk) begin
      shift  <= shift_next;
`ifdef UART_TX_PARITY_EN
      parity <= parity_next;
`endif
   end

   always_comb begin
      state_next  = state;
      shift_next  = shift;
      sample_next = sample_cnt;
      bit_next    = bit_cnt;
`ifdef UART_TX_PARITY_EN
      parity_next = parity;
`endif
      bit_done = sample_ENABLE && (sample_cnt == SCW'(SAMPLES_PER_BIT - 1));

      if (state != IDLE && sample_ENABLE)
         sample_next = bit_done ? '0 : sample_cnt + 1'b1;

      case (state)
         IDLE: begin
            if (Tx_WR && Tx_EN) begin
               shift_next  = Tx_DATA;
               sample_next = '0;
               bit_next    = '0;
               state_next  = START;
`ifdef UART_TX_PARITY_EN
               parity_next = ^Tx_DATA;
`endif
            end
         end
         START: if (bit_done) state_next = DATA;
         DATA: begin
            if (bit_done) begin
               shift_next = shift >> 1;
               bit_next   = bit_cnt + 1'b1;
               if (bit_cnt == BCW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_done) state_next = STOP;
`endif
         STOP: if (bit_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // Dropping the enable aborts any frame on the next edge.
      if (!Tx_EN) begin
         state_next  = IDLE;
         sample_next = '0;
         bit_next    = '0;
      end

      busy_next = (state_next != IDLE);
      case (state_next)
         START:   txd_next = 1'b0;
         DATA:    txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  txd_next = parity_next;
`endif
         default: txd_next = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter; frame contents follow UART_TX_PARITY_EN when defined.
// Frames are captured per sample strobe and compared with a bit-list model of the UART frame.
module tb_uart_transmitter;

   localparam int SPB = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] baud_select;
   logic       Tx_EN;
   logic       Tx_WR;
   logic [7:0] Tx_DATA;
   logic       TxD;
   logic       Tx_BUSY;

   int   n_cmp = 0;
   int   n_bad = 0;

   logic cap_bits[$];
   logic exp_bits[$];
   int   cap_cycles;
   int   cap_wait;
   logic cap_ok;
   logic cap_first;

   always #5 clk = ~clk;

   uart_transmitter dut (
      .clk         (clk),
      .reset       (reset),
      .baud_select (baud_select),
      .Tx_EN       (Tx_EN),
      .Tx_WR       (Tx_WR),
      .Tx_DATA     (Tx_DATA),
      .TxD         (TxD),
      .Tx_BUSY     (Tx_BUSY)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference frame: start 0, data LSB first, even parity when enabled, stop 1.
   task automatic build_expected(input logic [7:0] d);
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
      exp_bits.push_back(($countones(d) % 2) == 1);
`endif
      exp_bits.push_back(1'b1);
   endtask

   task automatic send_byte(input logic [7:0] d);
      Tx_DATA = d;
      Tx_WR   = 1'b1;
      @(negedge clk);
      Tx_WR   = 1'b0;
   endtask

   // Waits for Tx_BUSY, then records TxD at every sample strobe until Tx_BUSY drops.
   task automatic capture_frame();
      cap_bits.delete();
      cap_cycles = 0;
      cap_wait   = 0;
      cap_ok     = 1'b1;
      cap_first  = 1'b1;
      forever begin
         @(negedge clk);
         if (Tx_BUSY) break;
         cap_wait++;
         if (cap_wait > 2000) begin
            cap_ok = 1'b0;
            return;
         end
      end
      cap_first = TxD;
      while (Tx_BUSY) begin
         cap_cycles++;
         if (dut.sample_ENABLE) cap_bits.push_back(TxD);
         if (cap_cycles > 40000) begin
            cap_ok = 1'b0;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_frame(input logic [7:0] d, input string name);
      int  nb;
      int  unstable;
      real ideal, lo, hi;
      build_expected(d);
      nb = exp_bits.size();
      check_val({name, "_captured"}, cap_ok, 1);
      check_val({name, "_start_level"}, cap_first, 0);
      check_val({name, "_pulses"}, cap_bits.size(), nb * SPB);
      if (cap_bits.size() == nb * SPB) begin
         for (int k = 0; k < nb; k++)
            check_val($sformatf("%s_bit%0d", name, k), cap_bits[k * SPB + SPB / 2], exp_bits[k]);
         unstable = 0;
         for (int i = 0; i < cap_bits.size(); i++)
            if (cap_bits[i] !== exp_bits[i / SPB]) unstable++;
         check_val({name, "_unstable_samples"}, unstable, 0);
      end
      ideal = 1.0e8 / (115200.0 * 16.0);
      lo    = (nb * SPB - 1) * ideal * 0.98;
      hi    = nb * SPB * ideal * 1.02;
      check_val({name, "_busy_cycles_in_range"}, (cap_cycles >= lo && cap_cycles <= hi), 1);
   endtask

   task automatic idle_check(input int n, input string name);
      int active = 0;
      repeat (n) begin
         @(negedge clk);
         if (Tx_BUSY !== 1'b0 || TxD !== 1'b1) active++;
      end
      check_val(name, active, 0);
   endtask

   initial begin
      logic [7:0] d0, d1;
      int cnt, guard, p, c16, c32;

      reset       = 1'b1;
      baud_select = 3'b111;
      Tx_EN       = 1'b0;
      Tx_WR       = 1'b0;
      Tx_DATA     = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_val("reset_txd", TxD, 1);
      check_val("reset_busy", Tx_BUSY, 0);
      idle_check(2000, "reset_quiet");

      send_byte(8'($urandom));
      idle_check(300, "wr_while_disabled_ignored");

      Tx_EN = 1'b1;
      repeat (5) @(negedge clk);

      fork
         capture_frame();
         begin
            send_byte(8'hA5);
            repeat (4000) @(negedge clk);
            send_byte(8'h3C);
         end
      join
      check_frame(8'hA5, "a5");
      idle_check(1500, "wr_while_busy_no_second_frame");

      build_expected(8'h07);
      p = exp_bits.size() * SPB;
      fork
         capture_frame();
         begin
            send_byte(8'h07);
            cnt   = 0;
            guard = 0;
            while (guard < 20000) begin
               if (Tx_BUSY && dut.sample_ENABLE) cnt++;
               if (cnt >= p) break;
               @(negedge clk);
               guard++;
            end
            send_byte(8'($urandom));
         end
      join
      check_frame(8'h07, "x07");
      idle_check(1200, "wr_on_stop_end_ignored");

      d0 = 8'($urandom);
      send_byte(d0);
      cnt   = 0;
      guard = 0;
      while (guard < 20000) begin
         if (Tx_BUSY && dut.sample_ENABLE) cnt++;
         if (cnt >= 4 * SPB + SPB / 2) break;
         @(negedge clk);
         guard++;
      end
      check_val("abort_data_bit3_level", TxD, d0[3]);
      Tx_EN = 1'b0;
      @(negedge clk);
      check_val("abort_txd", TxD, 1);
      check_val("abort_busy", Tx_BUSY, 0);
      repeat (3) @(negedge clk);
      Tx_EN = 1'b1;
      repeat (5) @(negedge clk);
      fork
         capture_frame();
         send_byte(8'h55);
      join
      check_frame(8'h55, "after_abort_55");

      d0 = 8'($urandom);
      d1 = 8'($urandom);
      fork
         capture_frame();
         send_byte(d0);
      join
      check_frame(d0, "b2b_first");
      fork
         capture_frame();
         send_byte(d1);
      join
      check_val("b2b_gap_cycles", cap_wait, 0);
      check_frame(d1, "b2b_second");

      baud_select = 3'b011;
      repeat (5) @(negedge clk);
      send_byte(8'h00);
      cnt   = 0;
      guard = 0;
      c16   = 0;
      c32   = 0;
      while (guard < 30000) begin
         if (Tx_BUSY && dut.sample_ENABLE) begin
            cnt++;
            if (cnt == SPB) c16 = guard;
            if (cnt == SPB + SPB / 2) check_val("b9600_data_bit0_level", TxD, 0);
            if (cnt == 2 * SPB) begin
               c32 = guard;
               break;
            end
         end
         @(negedge clk);
         guard++;
      end
      check_val("b9600_bit_cycles_in_range", (c32 - c16 >= 10312 && c32 - c16 <= 10521), 1);
      reset = 1'b1;
      @(negedge clk);
      check_val("midframe_reset_txd", TxD, 1);
      check_val("midframe_reset_busy", Tx_BUSY, 0);
      reset = 1'b0;
      idle_check(50, "after_reset_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
